// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the FSM state enum, the next-PC select enum and parameter defaults.
package inst_fetch_pkg;

    localparam int          PW_DEF         = 10;
    localparam int unsigned START_ADDR_DEF = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_INC   = 2'd1,
        SEL_JMP   = 2'd2,
        SEL_START = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/inst_fetch_next_pc.sv
// Next-PC selector: hold, increment, absolute jump target, or start address.
// Ports: Sel_i, Pc_i, Target_i -> Next_o, AtMax_o (Pc_i is the last ROM word).
module next_pc
    import inst_fetch_pkg::*;
#(
    parameter int          PW         = PW_DEF,
    parameter int unsigned START_ADDR = START_ADDR_DEF
) (
    input  pc_sel_e       Sel_i,
    input  logic [PW-1:0] Pc_i,
    input  logic [7:0]    Target_i,
    output logic [PW-1:0] Next_o,
    output logic          AtMax_o
);

    logic [PW:0] inc;

    // Carry out of the increment flags the last address; it is
    // independent of Sel_i so the FSM can use it to pick Sel_i.
    assign inc     = {1'b0, Pc_i} + {{PW{1'b0}}, 1'b1};
    assign AtMax_o = inc[PW];

    always_comb begin
        Next_o = Pc_i;
        unique case (Sel_i)
            SEL_HOLD:  Next_o = Pc_i;
            SEL_INC:   Next_o = inc[PW-1:0];
            SEL_JMP:   Next_o = PW'(Target_i);
            SEL_START: Next_o = PW'(START_ADDR);
            default:   Next_o = Pc_i;
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch FSM (IDLE/RUN/HALTED) driving the program counter.
// Ports: Clk, Reset, Start, Halt, Jmp, Cond, Target[7:0], Stall ->
//   ProgCtr[PW-1:0], InstValid, Done, Fault; CycleCount[15:0] when
//   FETCH_CYCLE_CNT_EN is defined.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          PW         = PW_DEF,
    parameter int unsigned START_ADDR = START_ADDR_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Jmp,
    input  logic          Cond,
    input  logic [7:0]    Target,
    input  logic          Stall,
`ifdef FETCH_CYCLE_CNT_EN
    output logic [15:0]   CycleCount,
`endif
    output logic [PW-1:0] ProgCtr,
    output logic          InstValid,
    output logic          Done,
    output logic          Fault
);

    state_e        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    pc_sel_e       sel;
    logic          at_max;
    logic          start_acc;

    next_pc #(
        .PW         (PW),
        .START_ADDR (START_ADDR)
    ) u_next_pc (
        .Sel_i    (sel),
        .Pc_i     (pc_q),
        .Target_i (Target),
        .Next_o   (pc_d),
        .AtMax_o  (at_max)
    );

    always_comb begin
        state_d   = state_q;
        sel       = SEL_HOLD;
        done_d    = done_q;
        fault_d   = fault_q;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE, HALTED: begin
                if (Start) begin
                    state_d   = RUN;
                    sel       = SEL_START;
                    done_d    = 1'b0;
                    fault_d   = 1'b0;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (Halt) begin
                        state_d = HALTED;
                        done_d  = 1'b1;
                    end else if (Jmp && Cond) begin
                        sel = SEL_JMP;
                    end else if (at_max) begin
                        // Refuse to wrap: stop with a fault.
                        state_d = HALTED;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        sel = SEL_INC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_acc) begin
            cnt_d = '0;
        end else if (state_q == RUN && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign CycleCount = cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

    assign ProgCtr   = pc_q;
    assign InstValid = (state_q == RUN) && !Stall;
    assign Done      = done_q;
    assign Fault     = fault_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter PW, default 10: program-counter width; instruction ROM depth is 2**PW.
REQ-002 Parameter START_ADDR, default 0: PC value loaded on every accepted Start.
REQ-003 Clk  input  1  the only clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  single-cycle request to begin program execution.
REQ-006 Halt  input  1  decoded halt instruction at the current PC.
REQ-007 Jmp  input  1  decoded jump instruction at the current PC.
REQ-008 Cond  input  1  jump condition, the overflow/flag register value; jump taken only when Jmp and Cond are both 1.
REQ-009 Target  input  8  register-file read port A value for the jump register, used as the absolute jump target.
REQ-010 Stall  input  1  holds the PC and state for one cycle per asserted cycle.
REQ-011 ProgCtr  output  PW  current instruction address.
REQ-012 InstValid  output  1  ProgCtr addresses a live instruction.
REQ-013 Done  output  1  program halted; held until the next Start or Reset.
REQ-014 Fault  output  1  PC overflowed past 2**PW-1; held until the next Start or Reset.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, HALTED.
REQ-016 IDLE: Start=1 -> RUN, ProgCtr<=START_ADDR next cycle; otherwise remain.
REQ-017 RUN, Stall=1: ProgCtr, state, Done and Fault hold; Halt, Jmp and Cond are ignored that cycle.
REQ-018 RUN, Stall=0, Halt=1: -> HALTED, Done<=1, ProgCtr holds (Halt has priority over Jmp).
REQ-019 RUN, Stall=0, Halt=0, Jmp=1, Cond=1: ProgCtr<={zero-extended Target} next cycle.
REQ-020 RUN, Stall=0, Halt=0, Jmp=1, Cond=0: not-taken jump; ProgCtr<=ProgCtr+1.
REQ-021 RUN, Stall=0, Halt=0, Jmp=0: ProgCtr<=ProgCtr+1.
REQ-022 Increment at ProgCtr=2**PW-1 SHALL NOT wrap silently: -> HALTED, Done<=1, Fault<=1, ProgCtr holds.
REQ-023 A taken jump at ProgCtr=2**PW-1 SHALL NOT fault.
REQ-024 HALTED: Start=1 -> RUN, ProgCtr<=START_ADDR, Done<=0, Fault<=0; otherwise remain.
REQ-025 Start asserted in RUN SHALL be ignored.
REQ-026 InstValid SHALL be 1 exactly when the state is RUN and combinationally 0 while Stall=1.
REQ-027 Latency: Start sampled at edge N -> InstValid=1 and ProgCtr=START_ADDR after edge N; each unstalled RUN cycle consumes exactly one instruction.

Reset
REQ-028 Reset SHALL have priority over all inputs including Start.
REQ-029 Reset SHALL force state IDLE, ProgCtr=0, InstValid=0, Done=0, Fault=0, and the cycle counter to 0.
REQ-030 Reset asserted mid-RUN SHALL abort the program without reaching HALTED.

Configuration
REQ-031 Macro FETCH_CYCLE_CNT_EN defined: add output CycleCount (16 bits) counting RUN cycles including stalls; it saturates at 16'hFFFF, clears on accepted Start, and holds in HALTED.
REQ-032 Macro FETCH_CYCLE_CNT_EN undefined: no CycleCount port and no counter logic.

Structure
REQ-033 Shared package SHALL hold the state enumeration (IDLE/RUN/HALTED), the PW default and the START_ADDR default.
REQ-034 Next-PC selection (hold / increment / jump target / start) SHALL be a sub-module, next_pc, with the FSM in inst_fetch.

Verification
REQ-035 Reset, then Start pulse -> ProgCtr=0, InstValid=1 next cycle; after 3 idle cycles ProgCtr=3.
REQ-036 ProgCtr=5, Jmp=1, Cond=1, Target=8'h40 -> ProgCtr=10'h040; repeat with Cond=0 -> ProgCtr=6.
REQ-037 Stall=1 for 2 cycles with Halt=1 -> ProgCtr unchanged, still RUN; Stall=0 -> HALTED, Done=1.
REQ-038 Halt=1 and Jmp=1 in the same cycle -> HALTED, ProgCtr unchanged, Done=1.
REQ-039 ProgCtr=10'h3FF, no jump -> HALTED, Done=1, Fault=1; then Start -> ProgCtr=0, Done=0, Fault=0.
REQ-040 Reset pulse mid-RUN at ProgCtr=7 -> IDLE, ProgCtr=0, Done=0; with FETCH_CYCLE_CNT_EN, CycleCount=0.
